// File: rtl/conv_result_reader.sv
// Drains result tiles from four 1-cycle-latency banks into 512-bit cachelines on a valid/ready stream.
// Start to first output_valid is 3 cycles; reads are throttled so the small output FIFO never overflows under backpressure.
module conv_result_reader #(
    parameter int ADDR_WIDTH = 13,
    parameter int BANK_WIDTH = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_address,
    input  logic [ADDR_WIDTH:0]       line_count,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_read_en,
    output logic [ADDR_WIDTH-1:0]     mem_read_address,
    input  logic [4*BANK_WIDTH-1:0]   mem_read_data,
    output logic                      output_valid,
    input  logic                      output_ready,
    output logic [4*BANK_WIDTH-1:0]   cacheline_out
);

    localparam int LW   = 4 * BANK_WIDTH;
    localparam int CNTW = ADDR_WIDTH + 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int OW   = CW + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNTW-1:0]       remain_q, remain_d;
    logic                  in_flight_q, in_flight_d;
    logic [LW-1:0]         fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, pop;
    logic [OW-1:0]         occupancy, occ_limit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push             = in_flight_q;
    assign output_valid     = (count_q != '0);
    assign pop              = output_valid & output_ready;
    assign cacheline_out    = fifo_mem_q[rd_ptr_q];
    assign mem_read_address = addr_q;

    // A pop this cycle frees a slot, so the limit is raised instead of subtracting.
    assign occupancy = OW'(in_flight_q) + OW'(count_q);
    assign occ_limit = OW'(FIFO_DEPTH) + OW'(pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_read_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_address;
                    remain_d = line_count;
                    state_d  = (line_count == '0) ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                busy = 1'b1;
                if (remain_q != '0 && occupancy < occ_limit) begin
                    mem_read_en = 1'b1;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    remain_d    = remain_q - CNTW'(1);
                    if (remain_q == CNTW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Leave on the edge of the final pop so done lands in the following cycle.
                if (!in_flight_q && count_d == '0) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_flight_d = mem_read_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            in_flight_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= mem_read_data;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed bench for conv_result_reader: table of transfers plus a start-while-busy / mid-stream reset sequence.
module tb_conv_result_reader;

    logic         clk;
    logic         reset;
    logic         start;
    logic [12:0]  base_address;
    logic [13:0]  line_count;
    logic         busy;
    logic         done;
    logic         mem_read_en;
    logic [12:0]  mem_read_address;
    logic [511:0] mem_read_data;
    logic         output_valid;
    logic         output_ready;
    logic [511:0] cacheline_out;

    int checks = 0;
    int errors = 0;

    conv_result_reader #(
        .ADDR_WIDTH(13),
        .BANK_WIDTH(128),
        .FIFO_DEPTH(2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_address     (base_address),
        .line_count       (line_count),
        .busy             (busy),
        .done             (done),
        .mem_read_en      (mem_read_en),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .output_valid     (output_valid),
        .output_ready     (output_ready),
        .cacheline_out    (cacheline_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] line_of(input logic [12:0] a);
        logic [511:0] l;
        for (int i = 0; i < 4; i++) begin
            l[128*i +: 128] = {32'(a), 32'(i), 32'hA5A5_0000 | 32'(a), 32'hC3C3_0000 | 32'(i)};
        end
        return l;
    endfunction

    // Bank model: 1-cycle read latency, garbage when not reading.
    initial mem_read_data = '0;
    always @(posedge clk) begin
        if (mem_read_en) mem_read_data <= line_of(mem_read_address);
        else             mem_read_data <= {16{32'hDEADBEEF}};
    end

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            1: case (c % 6)
                   0, 3, 5: return 1'b1;
                   default: return 1'b0;
               endcase
            2: return (c >= 8);
            default: return 1'b1;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [12:0] base;
        logic [13:0] cnt;
        int          mode;
        int          exp_lat;
        int          exp_done;
        logic [12:0] exp_last;
    } vec_t;

    // Called just after a falling edge; drives start for the next rising edge.
    task automatic run_xfer(input int idx, input logic [12:0] b, input logic [13:0] n, input int mode,
                            input int exp_lat, input int exp_done, input logic [12:0] exp_last);
        int cyc, issued, popped, first_lat, done_cyc, data_err, addr_err, stab_err, busy_err, max_occ, budget;
        logic prev_hold;
        logic [511:0] prev_data;
        logic [12:0] last_addr;
        bit done_seen;
        string p;
        cyc = 0; issued = 0; popped = 0; first_lat = -1; done_cyc = -1;
        data_err = 0; addr_err = 0; stab_err = 0; busy_err = 0; max_occ = 0;
        prev_hold = 1'b0; prev_data = '0; last_addr = '0; done_seen = 1'b0;
        budget = int'(n) * 4 + 40;
        p = $sformatf("v%0d", idx);
        start = 1'b1; base_address = b; line_count = n; output_ready = ready_for(mode, 0);
        while (!done_seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            output_ready = ready_for(mode, cyc);
            #1;
            if (prev_hold && (!output_valid || cacheline_out !== prev_data)) stab_err++;
            if (output_valid && first_lat < 0) first_lat = cyc;
            if (mem_read_en) begin
                if (mem_read_address != b + 13'(issued)) addr_err++;
                issued++;
            end
            if (output_valid && output_ready) begin
                if (cacheline_out !== line_of(b + 13'(popped))) data_err++;
                last_addr = b + 13'(popped);
                popped++;
            end
            if (issued - popped > max_occ) max_occ = issued - popped;
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                if (busy) busy_err++;
            end else if (!busy && n != 0) begin
                busy_err++;
            end
            prev_hold = output_valid && !output_ready;
            prev_data = cacheline_out;
        end
        check({p, "_no_timeout"}, done_seen, 1);
        check({p, "_lines_out"}, popped, int'(n));
        check({p, "_reads_issued"}, issued, int'(n));
        check({p, "_first_valid_lat"}, first_lat, exp_lat);
        check({p, "_done_cycle"}, done_cyc, exp_done);
        check({p, "_data_errs"}, data_err, 0);
        check({p, "_addr_errs"}, addr_err, 0);
        check({p, "_stall_hold_errs"}, stab_err, 0);
        check({p, "_busy_errs"}, busy_err, 0);
        check({p, "_occupancy_le2"}, (max_occ <= 2), 1);
        if (n != 0) check({p, "_last_addr"}, last_addr, exp_last);
        @(negedge clk);
        #1;
        check({p, "_done_single"}, done, 0);
        check({p, "_busy_after"}, busy, 0);
        check({p, "_valid_after"}, output_valid, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int ni, np, done_cnt;
        vecs[0] = '{13'd0,    14'd4,    0, 3,  7,    13'd3};
        vecs[1] = '{13'd20,   14'd6,    1, 3,  13,   13'd25};
        vecs[2] = '{13'd8190, 14'd4,    0, 3,  7,    13'd1};
        vecs[3] = '{13'd0,    14'd0,    0, -1, 1,    13'd0};
        vecs[4] = '{13'd8000, 14'd5,    2, 3,  13,   13'd8004};
        vecs[5] = '{13'd0,    14'd8192, 0, 3,  8195, 13'd8191};

        reset = 1'b0; start = 1'b0; base_address = '0; line_count = '0; output_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_read_en, 0);
        check("rst_rd_addr", mem_read_address, 0);
        check("rst_valid", output_valid, 0);
        check_line("rst_line", cacheline_out, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_xfer(i, vecs[i].base, vecs[i].cnt, vecs[i].mode,
                     vecs[i].exp_lat, vecs[i].exp_done, vecs[i].exp_last);
        end

        // Start while busy is ignored, then reset mid-stream.
        ni = 0; np = 0; done_cnt = 0;
        start = 1'b1; base_address = 13'd50; line_count = 14'd10; output_ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = (c == 3);
            if (c == 3) begin
                base_address = 13'd300;
                line_count   = 14'd1;
            end
            #1;
            if (mem_read_en) begin
                check("busy_start_rd_addr", mem_read_address, 13'd50 + 13'(ni));
                ni++;
            end
            if (output_valid && output_ready) begin
                check_line("busy_start_line", cacheline_out, line_of(13'd50 + 13'(np)));
                np++;
            end
            if (done) done_cnt++;
        end
        check("busy_start_lines", np, 5);
        check("busy_start_still_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_en", mem_read_en, 0);
        check("midrst_rd_addr", mem_read_address, 0);
        check("midrst_valid", output_valid, 0);
        check_line("midrst_line", cacheline_out, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) reset = 1'b1;
            #1;
            if (done) done_cnt++;
            if (output_valid) done_cnt += 100;
        end
        check("midrst_no_done_no_valid", done_cnt, 0);

        run_xfer(6, 13'd100, 14'd2, 0, 3, 5, 13'd101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
